// File: rtl/line_window_3x3.sv
// 3x3 trailing window over a raster pixel stream, built from two line buffers
// and per-row column shifters. Window, sync and coordinates leave 2 cycles late.
module line_window_3x3 #(
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = 1920,
    parameter int COORD_W  = 12
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     pixel_in,
    input  logic                  de_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic [9*DATA_W-1:0]   win_out,
    output logic                  de_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  win_full,
    output logic [COORD_W-1:0]    x_out,
    output logic [COORD_W-1:0]    y_out
);
    localparam int ADDR_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] ROW_MAX  = '1;

    logic               de_prev_q, vs_prev_q;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d, cur_col;
    logic               line_start, de_fall, vs_rise, overlong, lb_we;
    logic [ADDR_W-1:0]  lb_addr;

    // cur_col is the column of the sample presented this cycle; col_q remembers it
    always_comb begin
        line_start = de_in & ~de_prev_q;
        de_fall    = de_prev_q & ~de_in;
        vs_rise    = vsync_in & ~vs_prev_q;
        overlong   = de_in & ~line_start & (col_q == COL_LAST);
        if (line_start) begin
            cur_col = '0;
        end else if (de_in && (col_q != COL_LAST)) begin
            cur_col = col_q + 1'b1;
        end else begin
            cur_col = col_q;
        end
        col_d = de_in ? cur_col : col_q;
        row_d = row_q;
        if (vs_rise) begin
            row_d = '0;
        end else if (de_fall && (row_q != ROW_MAX)) begin
            row_d = row_q + 1'b1;
        end
        lb_we   = de_in & ~overlong & ~reset;
        lb_addr = cur_col[ADDR_W-1:0];
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            de_prev_q <= de_in;
            vs_prev_q <= vsync_in;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    // Read-first line buffers: lb0 holds row r-1, lb1 holds row r-2. Not cleared;
    // the row mask below keeps stale contents out of the window.
    logic [DATA_W-1:0] lb0_mem [H_ACTIVE];
    logic [DATA_W-1:0] lb1_mem [H_ACTIVE];
    logic [DATA_W-1:0] rd0_q, rd1_q;

    always_ff @(posedge clk_pixel) begin
        if (de_in) begin
            rd0_q <= lb0_mem[lb_addr];
            rd1_q <= lb1_mem[lb_addr];
        end
        if (lb_we) begin
            lb0_mem[lb_addr] <= pixel_in;
            lb1_mem[lb_addr] <= lb0_mem[lb_addr];
        end
    end

    logic               s1_de_q, s1_hs_q, s1_vs_q, s1_ls_q;
    logic [COORD_W-1:0] s1_col_q, s1_row_q;
    logic [DATA_W-1:0]  s1_pix_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            s1_de_q  <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_ls_q  <= 1'b0;
            s1_col_q <= '0;
            s1_row_q <= '0;
            s1_pix_q <= '0;
        end else begin
            s1_de_q  <= de_in;
            s1_hs_q  <= hsync_in;
            s1_vs_q  <= vsync_in;
            s1_ls_q  <= line_start;
            s1_col_q <= cur_col;
            s1_row_q <= row_q;
            s1_pix_q <= pixel_in;
        end
    end

    // win_q[i][j]: i=0 row r-2 .. i=2 row r; j=0 column c-2 .. j=2 column c
    logic [2:0][2:0][DATA_W-1:0] win_q, win_d;
    logic [2:0][DATA_W-1:0]      tap_new;
    logic                        full_d;

    always_comb begin
        tap_new[0] = (s1_row_q >= COORD_W'(2)) ? rd1_q : '0;
        tap_new[1] = (s1_row_q >= COORD_W'(1)) ? rd0_q : '0;
        tap_new[2] = s1_pix_q;
        win_d = win_q;
        if (s1_de_q) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][2] = tap_new[i];
                win_d[i][1] = s1_ls_q ? '0 : win_q[i][2];
                win_d[i][0] = s1_ls_q ? '0 : win_q[i][1];
            end
        end
        full_d = s1_de_q && (s1_row_q >= COORD_W'(2)) && (s1_col_q >= COORD_W'(2));
    end

    logic               de_o_q, hs_o_q, vs_o_q, full_o_q;
    logic [COORD_W-1:0] x_o_q, y_o_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            win_q    <= '0;
            de_o_q   <= 1'b0;
            hs_o_q   <= 1'b0;
            vs_o_q   <= 1'b0;
            full_o_q <= 1'b0;
            x_o_q    <= '0;
            y_o_q    <= '0;
        end else begin
            win_q    <= win_d;
            de_o_q   <= s1_de_q;
            hs_o_q   <= s1_hs_q;
            vs_o_q   <= s1_vs_q;
            full_o_q <= full_d;
            x_o_q    <= s1_col_q;
            y_o_q    <= s1_row_q;
        end
    end

    assign win_out   = win_q;
    assign de_out    = de_o_q;
    assign hsync_out = hs_o_q;
    assign vsync_out = vs_o_q;
    assign win_full  = full_o_q;
    assign x_out     = x_o_q;
    assign y_out     = y_o_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 with H_ACTIVE=8; outputs are snapshotted
// every cycle so each input sample can be matched with its result 2 cycles later.
module tb_line_window_3x3;
    localparam int DW = 8;
    localparam int HA = 8;
    localparam int CW = 12;
    localparam int HN = 1024;

    logic            clk_pixel;
    logic            reset;
    logic [DW-1:0]   pixel_in;
    logic            de_in, hsync_in, vsync_in;
    logic [9*DW-1:0] win_out;
    logic            de_out, hsync_out, vsync_out, win_full;
    logic [CW-1:0]   x_out, y_out;

    line_window_3x3 #(.DATA_W(DW), .H_ACTIVE(HA), .COORD_W(CW)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .pixel_in  (pixel_in),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .win_out   (win_out),
        .de_out    (de_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .win_full  (win_full),
        .x_out     (x_out),
        .y_out     (y_out)
    );

    initial begin
        clk_pixel = 1'b0;
        forever #5 clk_pixel = ~clk_pixel;
    end

    int n_pass, n_total, tick;
    int ltick [16];
    int bl_tick;
    logic [9*DW-1:0] h_win [HN];
    logic            h_de [HN];
    logic            h_hs [HN];
    logic            h_vs [HN];
    logic            h_full [HN];
    logic [CW-1:0]   h_x [HN];
    logic [CW-1:0]   h_y [HN];

    // snapshot (result of the inputs from 2 calls ago), then drive new inputs
    task automatic cyc(input logic rst, input logic de, input logic hs, input logic vs,
                       input logic [7:0] pix);
        @(negedge clk_pixel);
        if (tick < HN) begin
            h_win[tick]  = win_out;
            h_de[tick]   = de_out;
            h_hs[tick]   = hsync_out;
            h_vs[tick]   = vsync_out;
            h_full[tick] = win_full;
            h_x[tick]    = x_out;
            h_y[tick]    = y_out;
        end
        reset    = rst;
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        pixel_in = pix;
        tick++;
    endtask

    task automatic line(input int row, input int ncols, input int add);
        for (int c = 0; c < ncols; c++) begin
            if (c < 16) ltick[c] = tick;
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(16 * row + c + 1 + add));
        end
        bl_tick = tick;
        for (int b = 0; b < 4; b++) cyc(1'b0, 1'b0, (b < 3) ? 1'b1 : 1'b0, 1'b0, 8'h00);
    endtask

    task automatic vblank(input int n);
        for (int v = 0; v < n; v++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [71:0] w9(input logic [7:0] k0, k1, k2, k3, k4, k5, k6, k7, k8);
        return {k8, k7, k6, k5, k4, k3, k2, k1, k0};
    endfunction

    int vt, l0_first, l0_bl, rt, de_cnt, t;

    initial begin
        reset = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; pixel_in = '0;
        n_pass = 0; n_total = 0; tick = 0;

        // reset with busy inputs
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_win",  72'(h_win[2]),  72'(0));
        chk("rst_de",   72'(h_de[2]),   72'(0));
        chk("rst_hs",   72'(h_hs[2]),   72'(0));
        chk("rst_vs",   72'(h_vs[2]),   72'(0));
        chk("rst_full", 72'(h_full[2]), 72'(0));
        chk("rst_x",    72'(h_x[2]),    72'(0));
        chk("rst_y",    72'(h_y[2]),    72'(0));

        // frame 1
        vt = tick;
        vblank(12);
        line(0, 8, 0);
        l0_first = ltick[0];
        l0_bl = bl_tick;
        chk("r0c0_win", h_win[ltick[0]+2], w9(0,0,0,0,0,0,0,0,8'h01));
        chk("r0c1_win", h_win[ltick[1]+2], w9(0,0,0,0,0,0,0,8'h01,8'h02));
        chk("r0c5_win", h_win[ltick[5]+2], w9(0,0,0,0,0,0,8'h04,8'h05,8'h06));
        chk("r0c5_x",   72'(h_x[ltick[5]+2]), 72'(5));
        chk("r0c6_win", h_win[ltick[6]+2], w9(0,0,0,0,0,0,8'h05,8'h06,8'h07));
        chk("r0c6_full", 72'(h_full[ltick[6]+2]), 72'(0));

        line(1, 8, 0);
        chk("r1c0_win", h_win[ltick[0]+2], w9(0,0,0,0,0,8'h01,0,0,8'h11));
        chk("r1c7_full", 72'(h_full[ltick[7]+2]), 72'(0));
        chk("r1c7_y",   72'(h_y[ltick[7]+2]), 72'(1));
        chk("hs_pre",   72'(h_hs[l0_bl+1]), 72'(0));
        chk("hs_p0",    72'(h_hs[l0_bl+2]), 72'(1));
        chk("hs_p1",    72'(h_hs[l0_bl+3]), 72'(1));
        chk("hs_p2",    72'(h_hs[l0_bl+4]), 72'(1));
        chk("hs_post",  72'(h_hs[l0_bl+5]), 72'(0));
        chk("de_lead",  72'(h_de[l0_first+1]), 72'(0));
        chk("de_first", 72'(h_de[l0_first+2]), 72'(1));
        de_cnt = 0;
        for (int k = l0_first + 2; k <= l0_first + 13; k++) de_cnt += int'(h_de[k]);
        chk("de_width", 72'(de_cnt), 72'(8));
        chk("vs_pre",   72'(h_vs[vt+1]),  72'(0));
        chk("vs_first", 72'(h_vs[vt+2]),  72'(1));
        chk("vs_last",  72'(h_vs[vt+13]), 72'(1));
        chk("vs_post",  72'(h_vs[vt+14]), 72'(0));

        line(2, 8, 0);
        t = ltick[2] + 2;
        chk("r2c2_win",  h_win[t], w9(8'h01,8'h02,8'h03,8'h11,8'h12,8'h13,8'h21,8'h22,8'h23));
        chk("r2c2_full", 72'(h_full[t]), 72'(1));
        chk("r2c2_de",   72'(h_de[t]), 72'(1));
        chk("r2c2_x",    72'(h_x[t]), 72'(2));
        chk("r2c2_y",    72'(h_y[t]), 72'(2));
        chk("r2c1_full", 72'(h_full[ltick[1]+2]), 72'(0));

        line(3, 8, 0);
        t = ltick[7] + 2;
        chk("r3c7_win",  h_win[t], w9(8'h16,8'h17,8'h18,8'h26,8'h27,8'h28,8'h36,8'h37,8'h38));
        chk("r3c7_full", 72'(h_full[t]), 72'(1));
        chk("blank_win", h_win[bl_tick+3], w9(8'h16,8'h17,8'h18,8'h26,8'h27,8'h28,8'h36,8'h37,8'h38));
        chk("blank_de",  72'(h_de[bl_tick+3]), 72'(0));
        chk("blank_full", 72'(h_full[bl_tick+3]), 72'(0));

        // frame 2, values offset by 0x80
        vblank(12);
        line(0, 8, 128);
        t = ltick[2] + 2;
        chk("f2r0_win", h_win[t], w9(0,0,0,0,0,0,8'h81,8'h82,8'h83));
        chk("f2r0_y",   72'(h_y[t]), 72'(0));
        line(1, 8, 128);
        chk("f2r1_win", h_win[ltick[2]+2], w9(0,0,0,8'h81,8'h82,8'h83,8'h91,8'h92,8'h93));
        line(2, 8, 128);
        t = ltick[2] + 2;
        chk("f2r2_win",  h_win[t], w9(8'h81,8'h82,8'h83,8'h91,8'h92,8'h93,8'hA1,8'hA2,8'hA3));
        chk("f2r2_full", 72'(h_full[t]), 72'(1));

        // reset mid-line at row 3, col 4
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hB1 + c));
        rt = tick;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hB5);
        for (int b = 0; b < 4; b++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("mrst_win",  h_win[rt+1], 72'(0));
        chk("mrst_de",   72'(h_de[rt+1]), 72'(0));
        chk("mrst_full", 72'(h_full[rt+1]), 72'(0));
        chk("mrst_x",    72'(h_x[rt+1]), 72'(0));
        chk("mrst_y",    72'(h_y[rt+1]), 72'(0));

        line(4, 8, 0);
        t = ltick[2] + 2;
        chk("pr0_win",  h_win[t], w9(0,0,0,0,0,0,8'h41,8'h42,8'h43));
        chk("pr0_y",    72'(h_y[t]), 72'(0));
        chk("pr0_full", 72'(h_full[t]), 72'(0));
        line(5, 8, 0);
        t = ltick[2] + 2;
        chk("pr1_win",  h_win[t], w9(0,0,0,8'h41,8'h42,8'h43,8'h51,8'h52,8'h53));
        chk("pr1_y",    72'(h_y[t]), 72'(1));
        chk("pr1_full", 72'(h_full[t]), 72'(0));

        // overlong line: 10 active samples
        line(6, 10, 0);
        chk("ovl_x7", 72'(h_x[ltick[7]+2]), 72'(7));
        chk("ovl_x8", 72'(h_x[ltick[8]+2]), 72'(7));
        chk("ovl_x9", 72'(h_x[ltick[9]+2]), 72'(7));
        chk("ovl_y",  72'(h_y[ltick[9]+2]), 72'(2));
        line(7, 8, 0);
        t = ltick[2] + 2;
        chk("aft_c2_win",  h_win[t], w9(8'h51,8'h52,8'h53,8'h61,8'h62,8'h63,8'h71,8'h72,8'h73));
        chk("aft_c2_full", 72'(h_full[t]), 72'(1));
        chk("aft_c2_y",    72'(h_y[t]), 72'(3));
        chk("aft_c7_win",  h_win[ltick[7]+2],
            w9(8'h56,8'h57,8'h58,8'h66,8'h67,8'h68,8'h76,8'h77,8'h78));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
